// File: rtl/register_file_3r1w.sv
// 32-entry MIPS register file: two bypassed combinational read ports, one
// unbypassed debug read port, one synchronous write port and a commit counter.
module register_file_3r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] DebugRegister,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] DebugData,
    output logic [15:0]           WriteCount
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 16;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en_c;

    // A write commits only out of reset, when enabled, and never to $0.
    assign wr_en_c = Reset && RegWrite && (WriteRegister != '0);

    // Storage and commit counter; counter wraps naturally at 16 bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            WriteCount <= '0;
        end else if (wr_en_c) begin
            mem[WriteRegister] <= WriteData;
            WriteCount         <= WriteCount + CNT_WIDTH'(1);
        end
    end

    // Read ports 1/2 forward same-cycle write data; reset forces zero.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        DebugData = '0;
        if (Reset) begin
            if (ReadRegister1 != '0) begin
                ReadData1 = (wr_en_c && (ReadRegister1 == WriteRegister))
                            ? WriteData : mem[ReadRegister1];
            end
            if (ReadRegister2 != '0) begin
                ReadData2 = (wr_en_c && (ReadRegister2 == WriteRegister))
                            ? WriteData : mem[ReadRegister2];
            end
            if (DebugRegister != '0) begin
                DebugData = mem[DebugRegister];
            end
        end
    end

endmodule

// File: tb/tb_register_file_3r1w.sv
// Scoreboard bench for register_file_3r1w: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_register_file_3r1w;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam int unsigned SIG_RD1 = 0;
    localparam int unsigned SIG_RD2 = 1;
    localparam int unsigned SIG_DBG = 2;
    localparam int unsigned SIG_WC  = 3;

    typedef struct {
        string       name;
        int unsigned sig;
        logic [31:0] val;
    } exp_t;

    logic          Clk;
    logic          Reset;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [AW-1:0] DebugRegister;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic [DW-1:0] DebugData;
    logic [15:0]   WriteCount;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    register_file_3r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .DebugRegister (DebugRegister),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .DebugData     (DebugData),
        .WriteCount    (WriteCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: outputs are stable mid-cycle, so every queued expectation is checked there.
    always @(negedge Clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_RD1: act = ReadData1;
                SIG_RD2: act = ReadData2;
                SIG_DBG: act = DebugData;
                default: act = {16'h0000, WriteCount};
            endcase
            n_checks++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
    end

    task automatic expect_val(input string name, input int unsigned sig, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_wr(input logic we, input int unsigned wr, input logic [31:0] wd);
        RegWrite      = we;
        WriteRegister = AW'(wr);
        WriteData     = wd;
    endtask

    task automatic set_rd(input int unsigned r1, input int unsigned r2, input int unsigned dr);
        ReadRegister1 = AW'(r1);
        ReadRegister2 = AW'(r2);
        DebugRegister = AW'(dr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        set_wr(1'b0, 0, 32'h0);
        set_rd(0, 0, 0);
        #1;

        // Reset state
        expect_val("reset_rd1", SIG_RD1, 32'h0);
        expect_val("reset_rd2", SIG_RD2, 32'h0);
        expect_val("reset_dbg", SIG_DBG, 32'h0);
        expect_val("reset_wc",  SIG_WC,  32'h0);
        step();
        step();
        Reset = 1'b1;

        // Basic write/read of $9
        set_wr(1'b1, 9, 32'h12345678);
        step();
        set_wr(1'b0, 0, 32'h0);
        set_rd(9, 0, 9);
        expect_val("basic_rd1", SIG_RD1, 32'h12345678);
        expect_val("basic_dbg", SIG_DBG, 32'h12345678);
        expect_val("basic_wc",  SIG_WC,  32'd1);
        step();

        // Zero register discards writes
        set_wr(1'b1, 0, 32'hFFFFFFFF);
        set_rd(0, 0, 0);
        expect_val("zero_pre_rd1", SIG_RD1, 32'h0);
        expect_val("zero_pre_rd2", SIG_RD2, 32'h0);
        step();
        set_wr(1'b0, 0, 32'h0);
        expect_val("zero_post_rd1", SIG_RD1, 32'h0);
        expect_val("zero_post_rd2", SIG_RD2, 32'h0);
        expect_val("zero_post_dbg", SIG_DBG, 32'h0);
        expect_val("zero_post_wc",  SIG_WC,  32'd1);
        step();

        // Same-cycle bypass on $10
        set_wr(1'b1, 10, 32'h0000000A);
        step();
        set_wr(1'b1, 10, 32'h000000BB);
        set_rd(10, 10, 10);
        expect_val("byp_rd1", SIG_RD1, 32'h000000BB);
        expect_val("byp_rd2", SIG_RD2, 32'h000000BB);
        expect_val("byp_dbg_old", SIG_DBG, 32'h0000000A);
        step();
        set_wr(1'b0, 0, 32'h0);
        expect_val("byp_dbg_new", SIG_DBG, 32'h000000BB);
        expect_val("byp_rd1_new", SIG_RD1, 32'h000000BB);
        expect_val("byp_wc", SIG_WC, 32'd3);
        step();

        // RegWrite low: no write, no bypass
        set_wr(1'b0, 17, 32'h55);
        set_rd(17, 0, 17);
        expect_val("nowe_rd1", SIG_RD1, 32'h0);
        step();
        expect_val("nowe_dbg", SIG_DBG, 32'h0);
        expect_val("nowe_wc",  SIG_WC,  32'd3);
        step();

        // Mid-run reset after writing $8
        set_wr(1'b1, 8, 32'hDEADBEEF);
        step();
        set_wr(1'b0, 0, 32'h0);
        set_rd(8, 8, 8);
        expect_val("rst_pre_rd1", SIG_RD1, 32'hDEADBEEF);
        expect_val("rst_pre_wc",  SIG_WC,  32'd4);
        step();
        Reset = 1'b0;
        set_wr(1'b1, 8, 32'h00000123);
        #1;
        n_checks++;
        if (ReadData1 === 32'h0) n_pass++;
        else $display("FAIL rst_imm_rd1: got %h expected 0", ReadData1);
        n_checks++;
        if (ReadData2 === 32'h0) n_pass++;
        else $display("FAIL rst_imm_rd2: got %h expected 0", ReadData2);
        n_checks++;
        if (DebugData === 32'h0) n_pass++;
        else $display("FAIL rst_imm_dbg: got %h expected 0", DebugData);
        n_checks++;
        if (WriteCount === 16'h0) n_pass++;
        else $display("FAIL rst_imm_wc: got %h expected 0", WriteCount);
        expect_val("rst_rd1", SIG_RD1, 32'h0);
        expect_val("rst_rd2", SIG_RD2, 32'h0);
        expect_val("rst_dbg", SIG_DBG, 32'h0);
        expect_val("rst_wc",  SIG_WC,  32'h0);
        step();
        Reset = 1'b1;
        set_wr(1'b0, 0, 32'h0);
        expect_val("rst_post_rd1", SIG_RD1, 32'h0);
        expect_val("rst_post_dbg", SIG_DBG, 32'h0);
        expect_val("rst_post_wc",  SIG_WC,  32'h0);
        step();

        // Full sweep: $i = i*3
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 32'(i), 32'(i * 3));
            step();
        end
        set_wr(1'b0, 0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            set_rd(32'(i), 32'(31 - i), 32'(i));
            expect_val($sformatf("sweep_rd1_%0d", i), SIG_RD1, 32'(i * 3));
            expect_val($sformatf("sweep_rd2_%0d", 31 - i), SIG_RD2, 32'((31 - i) * 3));
            step();
        end
        expect_val("sweep_wc", SIG_WC, 32'd31);
        step();

        // 65536 valid writes wrap the counter back to 31; last write is 0xFFFF to $2
        for (int k = 0; k < 65536; k++) begin
            set_wr(1'b1, 32'((k % 31) + 1), 32'(k));
            step();
        end
        set_wr(1'b0, 0, 32'h0);
        set_rd(2, 0, 2);
        expect_val("wrap_wc",  SIG_WC,  32'd31);
        expect_val("wrap_rd1", SIG_RD1, 32'h0000FFFF);
        expect_val("wrap_rd2", SIG_RD2, 32'h0);
        step();

        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
